// File: rtl/fp_mat_serializer_if.sv
// Matrix load / element stream bus between the matrix-multiply stage, the
// serializer and its downstream consumer.
interface fp_mat_serializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 8,
  parameter int COLS       = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  // Matrix load channel
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_WIDTH*ROWS*COLS-1:0] in_mat;
  logic                            in_trans;

  // Element stream channel
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [RW-1:0]                   out_row;
  logic [CW-1:0]                   out_col;
  logic                            out_last;

  // Environment side: supplies matrices, consumes elements
  modport master (
    output in_valid, in_mat, in_trans, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last
  );

  // Serializer side
  modport slave (
    input  in_valid, in_mat, in_trans, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last
  );
endinterface

// File: rtl/fp_mat_serializer.sv
// Captures a whole ROWS x COLS fixed-point matrix in one load beat and streams
// it out one element per accepted beat, row-major or column-major (transposed).
// Elements are copied bit-exact; all stream outputs are driven from registers.
module fp_mat_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 8,
  parameter int COLS       = 8
) (
  input logic                  clk,
  input logic                  rst,
  fp_mat_serializer_if.slave   bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MW = DATA_WIDTH * ROWS * COLS;

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic          SINGLE  = (ROWS == 1) && (COLS == 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state;
  logic [MW-1:0]         mat;
  logic                  trans;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [RW-1:0]         nrow;
  logic [CW-1:0]         ncol;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  // Element (r,c) of a flattened row-major matrix
  function automatic logic [DATA_WIDTH-1:0] elem(input logic [MW-1:0] m,
                                                 input logic [RW-1:0] r,
                                                 input logic [CW-1:0] c);
    int idx;
    idx = int'(r) * COLS + int'(c);
    return m[DATA_WIDTH*idx +: DATA_WIDTH];
  endfunction

  // Next (row,col) after an accepted beat; the wrap out of the final cell is
  // never used because the last accept returns to IDLE
  always_comb begin
    nrow = row;
    ncol = col;
    if (trans) begin
      if (row == ROW_MAX) begin
        nrow = '0;
        ncol = col + 1'b1;
      end else begin
        nrow = row + 1'b1;
      end
    end else begin
      if (col == COL_MAX) begin
        ncol = '0;
        nrow = row + 1'b1;
      end else begin
        ncol = col + 1'b1;
      end
    end
  end

  // Matrix storage: pure data, loaded only when a load beat is taken
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      mat <= bus.in_mat;
    end
  end

  // Load/stream FSM with registered handshake, index and element outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      last  <= 1'b0;
      row   <= '0;
      col   <= '0;
      data  <= '0;
      trans <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            trans <= bus.in_trans;
            row   <= '0;
            col   <= '0;
            data  <= bus.in_mat[DATA_WIDTH-1:0];
            last  <= SINGLE;
            valid <= 1'b1;
            ready <= 1'b0;
            state <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (last) begin
              valid <= 1'b0;
              ready <= 1'b1;
              last  <= 1'b0;
              state <= IDLE;
            end else begin
              row  <= nrow;
              col  <= ncol;
              data <= elem(mat, nrow, ncol);
              last <= (nrow == ROW_MAX) && (ncol == COL_MAX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_data  = data;
  assign bus.out_row   = row;
  assign bus.out_col   = col;
  assign bus.out_last  = last;
endmodule

// File: tb/tb_fp_mat_serializer.sv
// Bench for fp_mat_serializer: a 2x3 instance driven by directed and random
// matrices against a queue-based order model, plus a 1x1 instance.
module tb_fp_mat_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fp_mat_serializer_if #(.DATA_WIDTH(16), .ROWS(2), .COLS(3)) ifa();
  fp_mat_serializer_if #(.DATA_WIDTH(16), .ROWS(1), .COLS(1)) ifb();

  fp_mat_serializer #(.DATA_WIDTH(16), .ROWS(2), .COLS(3)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  fp_mat_serializer #(.DATA_WIDTH(16), .ROWS(1), .COLS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
  } beat_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // 2x3 matrix with element (r,c) = 16'h0r0c
  function automatic logic [95:0] pattern();
    logic [95:0] m;
    m = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        m[16*(r*3+c) +: 16] = {8'(r), 8'(c)};
    return m;
  endfunction

  function automatic logic [95:0] rand_mat();
    logic [95:0] m;
    for (int k = 0; k < 6; k++) m[16*k +: 16] = 16'($urandom);
    return m;
  endfunction

  // One full load + stream on the 2x3 instance. Called at a negedge with the
  // block idle. stall_idx: hold out_ready low 3 cycles when that beat index
  // is presented. intrude: offer an all-ones matrix during the stream.
  // abort_after: pulse reset after that many accepted beats (-1 = never).
  task automatic run_a(input logic [95:0] m, input logic tr, input int ready_pct,
                       input int stall_idx, input logic intrude, input int abort_after);
    beat_t q[$];
    beat_t b;
    int    accepted = 0;
    int    stall    = 0;
    int    cycles   = 0;
    logic  rdy;
    // Expected order straight from the definition of each traversal
    if (!tr) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 3; c++) begin
          b.d = m[16*(r*3+c) +: 16]; b.r = r; b.c = c; q.push_back(b);
        end
    end else begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 2; r++) begin
          b.d = m[16*(r*3+c) +: 16]; b.r = r; b.c = c; q.push_back(b);
        end
    end

    check("idle_in_ready", 32'(ifa.in_ready), 1);
    check("idle_out_valid", 32'(ifa.out_valid), 0);
    ifa.in_valid  = 1'b1;
    ifa.in_mat    = m;
    ifa.in_trans  = tr;
    ifa.out_ready = 1'b0;
    @(negedge clk);
    ifa.in_valid = intrude;
    if (intrude) ifa.in_mat = '1;

    while (q.size() > 0 && cycles < 200) begin
      check("busy_in_ready", 32'(ifa.in_ready), 0);
      check("out_valid", 32'(ifa.out_valid), 1);
      check("out_data", 32'(ifa.out_data), 32'(q[0].d));
      check("out_row", 32'(ifa.out_row), 32'(q[0].r));
      check("out_col", 32'(ifa.out_col), 32'(q[0].c));
      check("out_last", 32'(ifa.out_last), 32'(q.size() == 1));
      if (abort_after >= 0 && accepted == abort_after) begin
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(ifa.out_valid), 0);
        check("rst_in_ready", 32'(ifa.in_ready), 1);
        check("rst_out_row", 32'(ifa.out_row), 0);
        check("rst_out_col", 32'(ifa.out_col), 0);
        check("rst_out_data", 32'(ifa.out_data), 0);
        check("rst_out_last", 32'(ifa.out_last), 0);
        ifa.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (accepted == stall_idx && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      ifa.out_ready = rdy;
      if (rdy) begin
        void'(q.pop_front());
        accepted++;
      end
      @(negedge clk);
      cycles++;
    end
    check("stream_beats_left", 32'(q.size()), 0);
    check("stream_accepted", 32'(accepted), 6);
    check("end_out_valid", 32'(ifa.out_valid), 0);
    check("end_in_ready", 32'(ifa.in_ready), 1);
    ifa.out_ready = 1'b0;
  endtask

  // Single-element matrix on the 1x1 instance
  task automatic run_b(input logic [15:0] d, input logic tr);
    check("b_idle_in_ready", 32'(ifb.in_ready), 1);
    ifb.in_valid  = 1'b1;
    ifb.in_mat    = d;
    ifb.in_trans  = tr;
    ifb.out_ready = 1'b1;
    @(negedge clk);
    ifb.in_valid = 1'b0;
    check("b_out_valid", 32'(ifb.out_valid), 1);
    check("b_out_data", 32'(ifb.out_data), 32'(d));
    check("b_out_row", 32'(ifb.out_row), 0);
    check("b_out_col", 32'(ifb.out_col), 0);
    check("b_out_last", 32'(ifb.out_last), 1);
    @(negedge clk);
    check("b_end_out_valid", 32'(ifb.out_valid), 0);
    check("b_end_in_ready", 32'(ifb.in_ready), 1);
    ifb.out_ready = 1'b0;
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_mat = '0; ifa.in_trans = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b1; ifb.in_mat = '1; ifb.in_trans = 1'b0; ifb.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    // in_valid on the 1x1 instance is held high during reset and must be ignored
    check("rst_in_ready", 32'(ifa.in_ready), 1);
    check("rst_out_valid", 32'(ifa.out_valid), 0);
    check("rst_out_last", 32'(ifa.out_last), 0);
    check("rst_out_row", 32'(ifa.out_row), 0);
    check("rst_out_col", 32'(ifa.out_col), 0);
    check("rst_out_data", 32'(ifa.out_data), 0);
    check("rst_b_out_valid", 32'(ifb.out_valid), 0);
    ifb.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_a(pattern(), 1'b0, 100, -1, 1'b0, -1);   // row-major, full rate
    run_a(pattern(), 1'b1, 100, -1, 1'b0, -1);   // transposed
    run_a(pattern(), 1'b0, 100, 2, 1'b0, -1);    // stall on 0002
    run_a(pattern(), 1'b1, 100, 3, 1'b0, -1);    // stall on transposed beat 3
    run_a(pattern(), 1'b0, 100, -1, 1'b1, -1);   // load offered during stream
    run_a('1, 1'b1, 100, -1, 1'b0, -1);          // that matrix, taken in IDLE
    run_a(pattern(), 1'b0, 100, -1, 1'b0, 2);    // reset after 2 beats
    run_a(pattern(), 1'b1, 100, -1, 1'b0, -1);   // restart at (0,0)

    for (int i = 0; i < 20; i++)
      run_a(rand_mat(), 1'($urandom), 60, -1, 1'b0, -1);

    run_b(16'h8001, 1'b0);
    run_b(16'h8001, 1'b1);
    run_b(16'($urandom), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
